// File: rtl/zap_shift_pipe.sv
// zap_shift_pipe: pipelined ARM-compatible barrel shifter with valid/ready flow control and tag sideband.
// Optional feature macro ZAP_SHIFT_SKID_EN adds a 2-entry output skid buffer with a registered o_ready.
module zap_shift_pipe #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 2,
  parameter int TAG_W     = 6,
  parameter int SHIFT_OPS = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [WIDTH-1:0]             i_source,
  input  logic [7:0]                   i_amount,
  input  logic                         i_carry,
  input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
  input  logic [TAG_W-1:0]             i_tag,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [WIDTH-1:0]             o_result,
  output logic                         o_carry,
  output logic [TAG_W-1:0]             o_tag
);
  localparam int SW = $clog2(SHIFT_OPS);
  localparam int LW = $clog2(WIDTH);
  localparam int L  = STAGES - 1;
  localparam logic [8:0] W9 = 9'(WIDTH);

  typedef enum logic [SW-1:0] {
    SH_LSL   = SW'(0),
    SH_LSR   = SW'(1),
    SH_ASR   = SW'(2),
    SH_ROR   = SW'(3),
    SH_RORI  = SW'(4),
    SH_ROR_1 = SW'(5),
    SH_RRC   = SW'(6)
  } shift_e;

  logic [WIDTH-1:0]        sh_res;
  logic                    sh_c;
  logic [WIDTH:0]          ext;
  logic signed [WIDTH:0]   ext_s;
  logic [WIDTH-1:0]        rot;
  logic [8:0]              amt9;

  // The extra bit below/above the operand captures the last bit shifted out as the carry.
  always_comb begin
    amt9   = {1'b0, i_amount};
    rot    = WIDTH'({i_source, i_source} >> i_amount[LW-1:0]);
    ext    = '0;
    ext_s  = '0;
    sh_res = i_source;
    sh_c   = 1'b0;
    case (shift_e'(i_shift_type))
      SH_LSL: begin
        if (amt9 == '0) begin
          sh_c = i_carry;
        end else if (amt9 <= W9) begin
          ext    = {1'b0, i_source} << i_amount;
          sh_res = ext[WIDTH-1:0];
          sh_c   = ext[WIDTH];
        end else begin
          sh_res = '0;
        end
      end
      SH_LSR: begin
        if (amt9 == '0) begin
          sh_c = i_carry;
        end else if (amt9 <= W9) begin
          ext    = {i_source, 1'b0} >> i_amount;
          sh_res = ext[WIDTH:1];
          sh_c   = ext[0];
        end else begin
          sh_res = '0;
        end
      end
      SH_ASR: begin
        if (amt9 == '0) begin
          sh_c = i_carry;
        end else if (amt9 < W9) begin
          ext_s  = $signed({i_source, 1'b0}) >>> i_amount;
          sh_res = ext_s[WIDTH:1];
          sh_c   = ext_s[0];
        end else begin
          sh_res = {WIDTH{i_source[WIDTH-1]}};
          sh_c   = i_source[WIDTH-1];
        end
      end
      SH_ROR, SH_RORI, SH_ROR_1: begin
        sh_res = rot;
        sh_c   = (i_amount == '0) ? i_carry : rot[WIDTH-1];
      end
      SH_RRC: begin
        sh_res = {i_carry, i_source[WIDTH-1:1]};
        sh_c   = i_source[0];
      end
      default: begin
        sh_res = i_source;
        sh_c   = 1'b0;
      end
    endcase
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] car_q, car_d;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic              sink_ok;
  logic              adv;
  logic              accept;

  assign adv    = !vld_q[L] || sink_ok;
  assign accept = i_valid && o_ready;

  always_comb begin
    vld_d = vld_q;
    car_d = car_q;
    res_d = res_q;
    tag_d = tag_q;
    if (adv) begin
      vld_d[0] = accept;
      res_d[0] = sh_res;
      car_d[0] = sh_c;
      tag_d[0] = i_tag;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        res_d[k] = res_q[k-1];
        car_d[k] = car_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
    if (i_flush) vld_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q <= '0;
      car_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      car_q <= car_d;
      res_q <= res_d;
      tag_q <= tag_d;
    end
  end

`ifdef ZAP_SHIFT_SKID_EN
  logic [1:0]       cnt_q, cnt_d, cnt_pop;
  logic             rdy_q, rdy_d;
  logic             pop, push;
  logic [1:0]       scar_q, scar_d;
  logic [WIDTH-1:0] sres_q [2];
  logic [WIDTH-1:0] sres_d [2];
  logic [TAG_W-1:0] stag_q [2];
  logic [TAG_W-1:0] stag_d [2];

  // rdy_q mirrors (cnt_q != 2), so accepting never needs i_ready combinationally.
  assign sink_ok  = (cnt_q != 2'd2);
  assign o_ready  = rdy_q && !i_flush;
  assign o_valid  = (cnt_q != 2'd0);
  assign o_result = sres_q[0];
  assign o_carry  = scar_q[0];
  assign o_tag    = stag_q[0];

  always_comb begin
    pop    = (cnt_q != 2'd0) && i_ready;
    push   = vld_q[L] && sink_ok;
    sres_d = sres_q;
    scar_d = scar_q;
    stag_d = stag_q;
    if (pop) begin
      sres_d[0] = sres_q[1];
      scar_d[0] = scar_q[1];
      stag_d[0] = stag_q[1];
    end
    cnt_pop = cnt_q - {1'b0, pop};
    if (push) begin
      sres_d[cnt_pop[0]] = res_q[L];
      scar_d[cnt_pop[0]] = car_q[L];
      stag_d[cnt_pop[0]] = tag_q[L];
    end
    cnt_d = cnt_pop + {1'b0, push};
    if (i_flush) cnt_d = '0;
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      rdy_q     <= 1'b1;
      scar_q    <= '0;
      sres_q[0] <= '0;
      sres_q[1] <= '0;
      stag_q[0] <= '0;
      stag_q[1] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      scar_q <= scar_d;
      sres_q <= sres_d;
      stag_q <= stag_d;
    end
  end
`else
  assign sink_ok  = i_ready;
  assign o_ready  = (!vld_q[L] || i_ready) && !i_flush;
  assign o_valid  = vld_q[L];
  assign o_result = res_q[L];
  assign o_carry  = car_q[L];
  assign o_tag    = tag_q[L];
`endif

endmodule

// File: tb/tb_zap_shift_pipe.sv
// Self-checking bench for zap_shift_pipe: directed vector table, flow-control sequences,
// and randomized traffic scored against an iterative shift model.
`timescale 1ns/1ps
module tb_zap_shift_pipe;
  localparam int W   = 32;
  localparam int S   = 2;
  localparam int TW  = 6;
  localparam int OPS = 5;
`ifdef ZAP_SHIFT_SKID_EN
  localparam int LAT = S + 1;
`else
  localparam int LAT = S;
`endif
  localparam logic [2:0] T_LSL = 3'd0, T_LSR = 3'd1, T_ASR = 3'd2, T_ROR = 3'd3,
                         T_RORI = 3'd4, T_ROR1 = 3'd5, T_RRC = 3'd6, T_UND = 3'd7;

  logic          clk = 1'b0;
  logic          i_reset, i_flush, i_valid, i_carry, i_ready;
  logic [W-1:0]  i_source;
  logic [7:0]    i_amount;
  logic [2:0]    i_shift_type;
  logic [TW-1:0] i_tag;
  logic          o_ready, o_valid, o_carry;
  logic [W-1:0]  o_result;
  logic [TW-1:0] o_tag;

  always #5 clk = ~clk;

  zap_shift_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW), .SHIFT_OPS(OPS)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_source(i_source), .i_amount(i_amount), .i_carry(i_carry), .i_shift_type(i_shift_type),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_carry(o_carry), .o_tag(o_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: apply n single-bit shifts, carry is the last bit to fall off.
  function automatic logic [W:0] model(input logic [2:0] t, input logic [W-1:0] s,
                                       input logic [7:0] n, input logic cin);
    logic [W-1:0] r;
    logic         c;
    r = s;
    c = cin;
    case (t)
      T_LSL: for (int i = 0; i < int'(n); i++) begin c = r[W-1]; r = r << 1; end
      T_LSR: for (int i = 0; i < int'(n); i++) begin c = r[0]; r = r >> 1; end
      T_ASR: for (int i = 0; i < int'(n); i++) begin c = r[0]; r = {r[W-1], r[W-1:1]}; end
      T_ROR, T_RORI, T_ROR1: begin
        for (int i = 0; i < int'(n); i++) r = {r[0], r[W-1:1]};
        if (n != 0) c = r[W-1];
      end
      T_RRC: begin r = {cin, s[W-1:1]}; c = s[0]; end
      default: c = 1'b0;
    endcase
    return {c, r};
  endfunction

  typedef struct {
    logic [W-1:0]  res;
    logic          c;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          q[$];
  int            n_out = 0;
  bit            have_prev = 0;
  logic          prev_v, prev_r, prev_c;
  logic [W-1:0]  prev_res;
  logic [TW-1:0] prev_tag;

  // Scoreboard: every output handshake must match the oldest accepted op.
  always @(negedge clk) begin
    logic [W:0] m;
    exp_t e;
    if (i_reset) begin
      q.delete();
      have_prev = 0;
    end else begin
      if (have_prev && prev_v && !prev_r) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_result", o_result, prev_res);
        chk("hold_carry", o_carry, prev_c);
        chk("hold_tag", o_tag, prev_tag);
      end
      if (o_valid && i_ready) begin
        n_out++;
        chk("out_pending", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_result", o_result, e.res);
          chk("out_carry", o_carry, e.c);
          chk("out_tag", o_tag, e.tag);
        end
      end
      if (i_flush) begin
        q.delete();
      end else if (i_valid && o_ready) begin
        m = model(i_shift_type, i_source, i_amount, i_carry);
        e.res = m[W-1:0];
        e.c   = m[W];
        e.tag = i_tag;
        q.push_back(e);
      end
      have_prev = !i_flush;
      prev_v    = o_valid;
      prev_r    = i_ready;
      prev_res  = o_result;
      prev_c    = o_carry;
      prev_tag  = o_tag;
    end
  end

  typedef struct {
    logic [2:0]   typ;
    logic [W-1:0] src;
    logic [7:0]   amt;
    logic         cin;
    logic [W-1:0] res;
    logic         c;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] t, input logic [W-1:0] s, input logic [7:0] n,
                        input logic cin, input logic [TW-1:0] tag);
    i_shift_type = t;
    i_source     = s;
    i_amount     = n;
    i_carry      = cin;
    i_tag        = tag;
  endtask

  task automatic apply_vec(input vec_t v, input logic [TW-1:0] tag);
    set_op(v.typ, v.src, v.amt, v.cin, tag);
    i_valid = 1'b1;
    i_ready = 1'b1;
    #1;
    chk("vec_accept", o_ready, 1);
    tick();
    i_valid = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      chk("vec_early", o_valid, 0);
      tick();
    end
    chk("vec_valid", o_valid, 1);
    chk("vec_result", o_result, v.res);
    chk("vec_carry", o_carry, v.c);
    chk("vec_tag", o_tag, tag);
    tick();
  endtask

  function automatic logic [7:0] pick_amt();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'd31;
      3:       return 8'd32;
      4:       return 8'd33;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int sent;
    int base;

    vecs[0]  = '{T_LSL,  32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1};
    vecs[1]  = '{T_LSL,  32'h8000_0001, 8'd33,  1'b0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{T_ASR,  32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[3]  = '{T_ROR,  32'h0000_0001, 8'd32,  1'b0, 32'h0000_0001, 1'b0};
    vecs[4]  = '{T_ROR,  32'h0000_0001, 8'd0,   1'b1, 32'h0000_0001, 1'b1};
    vecs[5]  = '{T_RRC,  32'h0000_0003, 8'd9,   1'b1, 32'h8000_0001, 1'b1};
    vecs[6]  = '{T_RORI, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1};
    vecs[7]  = '{T_LSL,  32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{T_LSR,  32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{T_LSR,  32'h8000_0001, 8'd1,   1'b0, 32'h4000_0000, 1'b1};
    vecs[10] = '{T_ASR,  32'h8000_0000, 8'd31,  1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{T_ASR,  32'h7FFF_FFFF, 8'd32,  1'b1, 32'h0000_0000, 1'b0};
    vecs[12] = '{T_ROR,  32'h0000_00F1, 8'd4,   1'b1, 32'h1000_000F, 1'b0};
    vecs[13] = '{T_ROR1, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1};
    vecs[14] = '{T_UND,  32'hDEAD_BEEF, 8'd5,   1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[15] = '{T_LSR,  32'hDEAD_BEEF, 8'd0,   1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[16] = '{T_ROR,  32'h8000_0000, 8'd64,  1'b0, 32'h8000_0000, 1'b1};
    vecs[17] = '{T_LSL,  32'h1234_5678, 8'd255, 1'b1, 32'h0000_0000, 1'b0};

    i_reset = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    set_op(T_LSL, '0, '0, 1'b0, '0);
    repeat (3) tick();
    chk("reset_valid", o_valid, 0);
    chk("reset_result", o_result, 0);
    chk("reset_carry", o_carry, 0);
    chk("reset_tag", o_tag, 0);
    i_reset = 1'b0;
    i_ready = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) apply_vec(vecs[i], TW'(i + 1));

    // Back-to-back burst with the consumer stalled for cycles 3..6.
    sent = 0;
    base = n_out;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      i_ready = !(c >= 3 && c <= 6);
      i_valid = 1'b1;
      set_op(3'($urandom_range(0, 6)), $urandom, pick_amt(), 1'($urandom), TW'(32 + sent));
      #1;
      if (o_ready) sent++;
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 20 && n_out - base < 8; c++) tick();
    chk("b2b_sent", sent, 8);
    chk("b2b_count", n_out - base, 8);

    // Flush with two ops in flight and a third offered in the flush cycle.
    base = n_out;
    i_ready = 1'b0;
    i_valid = 1'b1;
    set_op(T_LSL, 32'h1, 8'd1, 1'b0, TW'(50));
    #1;
    chk("flush_acc0", o_ready, 1);
    tick();
    set_op(T_LSR, 32'h10, 8'd2, 1'b0, TW'(51));
    #1;
    chk("flush_acc1", o_ready, 1);
    tick();
    set_op(T_ASR, 32'h100, 8'd3, 1'b0, TW'(52));
    i_flush = 1'b1;
    #1;
    chk("flush_oready", o_ready, 0);
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_ovalid", o_valid, 0);
    i_ready = 1'b1;
    repeat (LAT + 3) tick();
    chk("flush_none", n_out - base, 0);
    apply_vec(vecs[0], TW'(60));

    // Random traffic with occasional flushes and one mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      i_reset = (c == 300);
      i_flush = ($urandom_range(0, 49) == 0);
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 3) != 0);
      set_op(3'($urandom_range(0, 7)), $urandom, pick_amt(), 1'($urandom), TW'($urandom));
      tick();
      if (c == 300) begin
        chk("midreset_valid", o_valid, 0);
        chk("midreset_result", o_result, 0);
        chk("midreset_tag", o_tag, 0);
      end
    end
    i_reset = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 20 && (q.size() != 0 || o_valid); c++) tick();
    chk("drain_empty", 64'(q.size()), 0);
    chk("drain_valid", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
